// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier: FSM state encoding and the
// default operand width used by every file of the block.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_multiplier_param_if.sv
// Handshake/data bundle of the Booth multiplier. The requester drives the
// master side (start, mode, operands); the multiplier sits on the slave side.
interface booth_multiplier_param_if #(
  parameter int WIDTH = booth_pkg::DEFAULT_WIDTH
);

  logic               start_sig;
  logic               signed_mode;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done_sig;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start_sig, signed_mode, A, B,
    input  busy, done_sig, product
  );

  modport slave (
    input  start_sig, signed_mode, A, B,
    output busy, done_sig, product
  );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: inspect P[1:0], add a or s (or nothing) into
// the upper WIDTH+1 bits, then shift the whole register arithmetically right.
module booth_step import booth_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH+2:0] p,
  input  logic [WIDTH:0]     a,
  input  logic [WIDTH:0]     s,
  output logic [2*WIDTH+2:0] p_next
);

  logic [WIDTH:0] upper;
  logic [WIDTH:0] sum;

  // Add/subtract selected by the Booth pair, then arithmetic shift by one.
  // The discarded LSB is P[0], so the shifted value reuses P[WIDTH+1:1].
  always_comb begin
    upper = p[2*WIDTH+2:WIDTH+2];
    sum   = upper;
    unique case (p[1:0])
      2'b01:   sum = upper + a;
      2'b10:   sum = upper + s;
      default: sum = upper;
    endcase
    p_next = {sum[WIDTH], sum, p[WIDTH+1:1]};
  end

endmodule

// File: rtl/booth_multiplier_param.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation.
// Operands are widened by one bit so the unsigned case is handled by the
// same signed datapath; WIDTH+1 Booth steps produce the exact product.
// Optional debug taps on a, s and P when BOOTH_MULT_DEBUG_EN is defined.
module booth_multiplier_param import booth_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  booth_multiplier_param_if.slave   bus
`ifdef BOOTH_MULT_DEBUG_EN
  ,
  output logic [WIDTH:0]            dbg_a,
  output logic [WIDTH:0]            dbg_s,
  output logic [2*WIDTH+2:0]        dbg_p
`endif
);

  localparam int PW = 2*WIDTH + 3;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH:0]     a_reg;
  logic [WIDTH:0]     s_reg;
  logic [PW-1:0]      p_reg;
  logic [PW-1:0]      p_step;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;
  logic               accept;
  logic               last_iter;
  logic               busy;
  logic               done;

  // Widen operands: sign bit replicated only in signed mode.
  assign a_ext = {bus.signed_mode & bus.A[WIDTH-1], bus.A};
  assign b_ext = {bus.signed_mode & bus.B[WIDTH-1], bus.B};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .a      (a_reg),
    .s      (s_reg),
    .p_next (p_step)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and control decode; start is only looked at in IDLE, so a
  // request during CALC or DONE has no effect.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_iter  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start_sig) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt_reg == LAST) begin
          last_iter  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand load on accept, one Booth step per CALC cycle, product capture
  // on the final step only so the output holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      s_reg       <= '0;
      p_reg       <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (accept) begin
      a_reg   <= a_ext;
      s_reg   <= -a_ext;
      p_reg   <= {{(WIDTH+1){1'b0}}, b_ext, 1'b0};
      cnt_reg <= '0;
    end else if (busy) begin
      p_reg   <= p_step;
      cnt_reg <= cnt_reg + 1'b1;
      if (last_iter) product_reg <= p_step[2*WIDTH:1];
    end
  end

  assign bus.busy     = busy;
  assign bus.done_sig = done;
  assign bus.product  = product_reg;

`ifdef BOOTH_MULT_DEBUG_EN
  assign dbg_a = a_reg;
  assign dbg_s = s_reg;
  assign dbg_p = p_reg;
`endif

endmodule

// File: tb/tb_booth_multiplier_param.sv
// Testbench for booth_multiplier_param: a WIDTH=8 instance driven from a
// vector table plus corner sequences, and a WIDTH=16 instance driven with
// random operands against an arithmetic reference model.
module tb_booth_multiplier_param;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  booth_multiplier_param_if #(.WIDTH(8))  if8 ();
  booth_multiplier_param_if #(.WIDTH(16)) if16 ();

`ifdef BOOTH_MULT_DEBUG_EN
  logic [8:0]  dbg_a8,  dbg_s8;
  logic [18:0] dbg_p8;
  logic [16:0] dbg_a16, dbg_s16;
  logic [34:0] dbg_p16;
`endif

  booth_multiplier_param #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
`ifdef BOOTH_MULT_DEBUG_EN
    ,
    .dbg_a (dbg_a8),
    .dbg_s (dbg_s8),
    .dbg_p (dbg_p8)
`endif
  );

  booth_multiplier_param #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
`ifdef BOOTH_MULT_DEBUG_EN
    ,
    .dbg_a (dbg_a16),
    .dbg_s (dbg_s16),
    .dbg_p (dbg_p16)
`endif
  );

  typedef struct {
    string       name;
    bit          sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Exact product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input logic [31:0] a, input logic [31:0] b);
    longint x, y, p;
    logic [63:0] mask;
    x = longint'({32'd0, a});
    y = longint'({32'd0, b});
    if (sm && a[w-1]) x = x - (longint'(1) << w);
    if (sm && b[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    mask = (64'd1 << (2*w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // One WIDTH=8 operation, called and returning at a falling edge.
  // glitch_at > 0 pulses start with other operands in that busy cycle.
  task automatic run8(input string name, input bit sm, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp, input int glitch_at);
    logic [15:0] prev;
    int cyc, busy_n, extra;
    bit held, got;
    prev = if8.product;
    if8.signed_mode = sm;
    if8.A = a;
    if8.B = b;
    if8.start_sig = 1'b1;
    @(negedge clk);
    if8.start_sig = 1'b0;
    cyc = 1; busy_n = 0; held = 1'b1; got = 1'b0;
    while (cyc <= 40) begin
      if (if8.done_sig) begin
        got = 1'b1;
        break;
      end
      if (if8.busy) busy_n++;
      if (if8.product !== prev) held = 1'b0;
      if (cyc == glitch_at) begin
        if8.start_sig   = 1'b1;
        if8.A           = 8'h55;
        if8.B           = 8'h22;
        if8.signed_mode = ~sm;
      end
      @(negedge clk);
      if8.start_sig = 1'b0;
      cyc++;
    end
    $display("op8 %s: sm=%0d A=%h B=%h product=%h done_cycle=%0d busy_cycles=%0d",
             name, sm, a, b, if8.product, cyc, busy_n);
    check({name, " done seen"}, 64'(got), 64'd1);
    check({name, " product"}, 64'(if8.product), 64'(exp));
    check({name, " latency"}, 64'(cyc), 64'd10);
    check({name, " busy cycles"}, 64'(busy_n), 64'd9);
    check({name, " product held"}, 64'(held), 64'd1);
    @(negedge clk);
    check({name, " done pulse width"}, 64'(if8.done_sig), 64'd0);
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      if (if8.done_sig || if8.busy) extra++;
      @(negedge clk);
    end
    check({name, " no extra activity"}, 64'(extra), 64'd0);
    check({name, " product after"}, 64'(if8.product), 64'(exp));
  endtask

  // WIDTH=16 stream with start held high: corners first, then 1000 random
  // operand pairs per mode; checks every product and the result spacing.
  task automatic run_random16();
    localparam int NOPS = 2002;
    logic [63:0] expq[$];
    logic [63:0] e;
    bit          sm;
    logic [15:0] a, b;
    int cyc, last_done, waited;
    bit got;
    cyc = 0; last_done = 0;
    for (int n = 0; n < NOPS; n++) begin
      if (n == 0)      begin sm = 1'b1; a = 16'h8000; b = 16'h8000; end
      else if (n == 1) begin sm = 1'b0; a = 16'hFFFF; b = 16'hFFFF; end
      else begin
        sm = (n >= 1002);
        a  = 16'($urandom);
        b  = 16'($urandom);
      end
      if16.signed_mode = sm;
      if16.A = a;
      if16.B = b;
      if16.start_sig = 1'b1;
      expq.push_back(ref_mul(16, sm, {16'd0, a}, {16'd0, b}));
      waited = 0; got = 1'b0;
      while (waited < 100) begin
        @(negedge clk);
        cyc++; waited++;
        if (if16.done_sig) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check("w16 done timeout", 64'(got), 64'd1);
        break;
      end
      e = expq.pop_front();
      $display("op16 #%0d: sm=%0d A=%h B=%h product=%h", n, sm, a, b, if16.product);
      check("w16 product", 64'(if16.product), e);
      if (n > 0) check("w16 spacing", 64'(cyc - last_done), 64'd19);
      last_done = cyc;
    end
    if16.start_sig = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"7 x -3 signed",      1'b1, 8'h07, 8'hFD, 16'hFFEB};
    vecs[1] = '{"FF x FF unsigned",   1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{"-1 x -1 signed",     1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3] = '{"-128 x -128",        1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[4] = '{"0 x -128",           1'b1, 8'h00, 8'h80, 16'h0000};
    vecs[5] = '{"3 x 4 unsigned",     1'b0, 8'h03, 8'h04, 16'h000C};
    vecs[6] = '{"-128 x 127",         1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[7] = '{"128 x 2 unsigned",   1'b0, 8'h80, 8'h02, 16'h0100};
    vecs[8] = '{"-1 x 1 signed",      1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[9] = '{"127 x 127 unsigned", 1'b0, 8'h7F, 8'h7F, 16'h3F01};

    rst_n = 1'b0;
    if8.start_sig = 1'b0;  if8.signed_mode = 1'b0;  if8.A = '0;  if8.B = '0;
    if16.start_sig = 1'b0; if16.signed_mode = 1'b0; if16.A = '0; if16.B = '0;
    repeat (3) @(negedge clk);
    check("reset busy8",     64'(if8.busy),      64'd0);
    check("reset done8",     64'(if8.done_sig),  64'd0);
    check("reset product8",  64'(if8.product),   64'd0);
    check("reset busy16",    64'(if16.busy),     64'd0);
    check("reset done16",    64'(if16.done_sig), 64'd0);
    check("reset product16", 64'(if16.product),  64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run8(vecs[i].name, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    // Start pulse with different operands during CALC cycle 3 is ignored.
    run8("start during calc", 1'b1, 8'h07, 8'hFD, 16'hFFEB, 3);

    // Reset in CALC cycle 5 aborts the operation and clears the outputs.
    if8.signed_mode = 1'b1;
    if8.A = 8'h07;
    if8.B = 8'hFD;
    if8.start_sig = 1'b1;
    @(negedge clk);
    if8.start_sig = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-calc busy", 64'(if8.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",    64'(if8.busy),     64'd0);
    check("abort done",    64'(if8.done_sig), 64'd0);
    check("abort product", 64'(if8.product),  64'd0);
    repeat (2) @(negedge clk);
    check("abort no done", 64'(if8.done_sig), 64'd0);
    rst_n = 1'b1;
    run8("3 x 4 after reset", 1'b0, 8'h03, 8'h04, 16'h000C, 0);

    run_random16();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
